// File: rtl/mult_acc_pkg.sv
// Shared types and constants for the packed-product lane accumulator.
// Holds the FSM state encoding, the lane widths and the mode encoding.
package mult_acc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   typedef enum logic {
      MODE_FULL  = 1'b0,
      MODE_SPLIT = 1'b1
   } mode_t;

   localparam int FULL_W = 12;
   localparam int HALF_W = 6;

endpackage

// File: rtl/mult_lane_extend.sv
// Widens one product lane to the accumulator width.
// The top bit is replicated when sign_ext is set; otherwise the lane is zero-filled.
module mult_lane_extend #(
   parameter int IN_W  = 12,
   parameter int ACC_W = 24
) (
   input  logic [IN_W-1:0]  lane_in,
   input  logic             sign_ext,
   output logic [ACC_W-1:0] lane_out
);

   always_comb begin
      if (sign_ext) begin
         lane_out = ACC_W'($signed(lane_in));
      end else begin
         lane_out = ACC_W'(lane_in);
      end
   end

endmodule

// File: rtl/mult_c3x2_lane_accumulator.sv
// Accumulates the packed 12-bit multiplier product over a frame of beats.
// The product is treated as one full lane or two 6-bit lanes, and each frame sum is offered on a valid/ready port.
module mult_c3x2_lane_accumulator
   import mult_acc_pkg::*;
#(
   parameter int ACC_W = 24,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [11:0]      C,
   input  logic             HALF_0,
   input  logic             HALF_1,
   input  logic             sign,
   input  logic [CNT_W-1:0] len,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc0,
   output logic [ACC_W-1:0] acc1,
   output logic             out_split,
   output logic [CNT_W-1:0] out_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   mode_t            mode_q, mode_d, mode_sel;
   logic             sign_q, sign_d, sign_sel;
   logic [CNT_W-1:0] len_q, len_d, len_eff;
   logic [CNT_W-1:0] count_q, count_d, count_inc;
   logic [ACC_W-1:0] acc0_q, acc0_d, acc1_q, acc1_d;
   logic [ACC_W-1:0] ext_full, ext_hi, ext_lo;
   logic [ACC_W-1:0] lane0, lane1;
   logic             accept;

   // On the first beat the mode/sign come straight from the ports; later beats use the latched copy.
   always_comb begin
      mode_sel = mode_q;
      sign_sel = sign_q;
      if (state_q == IDLE) begin
         mode_sel = (HALF_1 & ~HALF_0) ? MODE_SPLIT : MODE_FULL;
         sign_sel = sign;
      end
   end

   mult_lane_extend #(.IN_W(FULL_W), .ACC_W(ACC_W)) u_ext_full (
      .lane_in(C), .sign_ext(sign_sel), .lane_out(ext_full)
   );
   mult_lane_extend #(.IN_W(HALF_W), .ACC_W(ACC_W)) u_ext_hi (
      .lane_in(C[11:6]), .sign_ext(sign_sel), .lane_out(ext_hi)
   );
   mult_lane_extend #(.IN_W(HALF_W), .ACC_W(ACC_W)) u_ext_lo (
      .lane_in(C[5:0]), .sign_ext(sign_sel), .lane_out(ext_lo)
   );

   always_comb begin
      lane0 = (mode_sel == MODE_SPLIT) ? ext_hi : ext_full;
      lane1 = (mode_sel == MODE_SPLIT) ? ext_lo : '0;
   end

   assign in_ready  = rst_n & (state_q != HOLD);
   assign out_valid = (state_q == HOLD);
   assign accept    = in_valid & in_ready;
   assign len_eff   = (len == '0) ? CNT_ONE : len;
   assign count_inc = count_q + CNT_ONE;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      sign_d  = sign_q;
      len_d   = len_q;
      count_d = count_q;
      acc0_d  = acc0_q;
      acc1_d  = acc1_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               mode_d  = mode_sel;
               sign_d  = sign;
               len_d   = len_eff;
               count_d = CNT_ONE;
               acc0_d  = lane0;
               acc1_d  = lane1;
               state_d = (len_eff == CNT_ONE) ? HOLD : ACC;
            end
         end
         ACC: begin
            if (accept) begin
               count_d = count_inc;
               acc0_d  = acc0_q + lane0;
               acc1_d  = acc1_q + lane1;
               if (count_inc == len_q) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mode_q  <= MODE_FULL;
         sign_q  <= 1'b0;
         len_q   <= '0;
         count_q <= '0;
         acc0_q  <= '0;
         acc1_q  <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         sign_q  <= sign_d;
         len_q   <= len_d;
         count_q <= count_d;
         acc0_q  <= acc0_d;
         acc1_q  <= acc1_d;
      end
   end

   assign acc0      = acc0_q;
   assign acc1      = acc1_q;
   assign out_split = (mode_q == MODE_SPLIT);
   assign out_count = count_q;

endmodule

// File: tb/tb_mult_c3x2_lane_accumulator.sv
// Scoreboard bench for the lane accumulator: a 24-bit and a 12-bit instance see identical stimulus.
// Expected frame sums are computed from an arithmetic model and queued when the frame is driven.
module tb_mult_c3x2_lane_accumulator;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [11:0] c_in;
   logic        half0, half1, sign_in;
   logic [7:0]  len_in;
   logic        out_ready;

   logic        in_ready, out_valid, out_split;
   logic [23:0] acc0, acc1;
   logic [7:0]  out_count;

   logic        in_ready12, out_valid12, out_split12;
   logic [11:0] acc0_12, acc1_12;
   logic [7:0]  out_count12;

   typedef struct {
      logic [23:0] a0;
      logic [23:0] a1;
      logic        sp;
      logic [7:0]  cnt;
   } exp_t;

   exp_t        sb[$];
   logic [11:0] beat_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   mult_c3x2_lane_accumulator #(.ACC_W(24), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .C(c_in), .HALF_0(half0), .HALF_1(half1), .sign(sign_in), .len(len_in),
      .out_valid(out_valid), .out_ready(out_ready), .acc0(acc0), .acc1(acc1),
      .out_split(out_split), .out_count(out_count)
   );

   mult_c3x2_lane_accumulator #(.ACC_W(12), .CNT_W(8)) dut12 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready12),
      .C(c_in), .HALF_0(half0), .HALF_1(half1), .sign(sign_in), .len(len_in),
      .out_valid(out_valid12), .out_ready(out_ready), .acc0(acc0_12), .acc1(acc1_12),
      .out_split(out_split12), .out_count(out_count12)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input exp_t e);
      check_eq({tag, "_acc0"},   32'(acc0), 32'(e.a0));
      check_eq({tag, "_acc1"},   32'(acc1), 32'(e.a1));
      check_eq({tag, "_split"},  32'(out_split), 32'(e.sp));
      check_eq({tag, "_count"},  32'(out_count), 32'(e.cnt));
      check_eq({tag, "_acc0_w12"}, 32'(acc0_12), 32'(e.a0[11:0]));
      check_eq({tag, "_acc1_w12"}, 32'(acc1_12), 32'(e.a1[11:0]));
   endtask

   // Drives the beats in beat_q as one frame and queues the model's expected result.
   task automatic send_frame(input logic h0, input logic h1, input logic sg, input logic [7:0] ln);
      exp_t e;
      int   s0, s1, v0, v1, hi, lo, c, nb, guard;
      logic split;
      split = h1 & ~h0;
      nb = (ln == 0) ? 1 : int'(ln);
      s0 = 0;
      s1 = 0;
      for (int i = 0; i < nb; i++) begin
         c = int'(beat_q[i]);
         if (split) begin
            hi = c / 64;
            lo = c % 64;
            v0 = (sg && hi >= 32) ? hi - 64 : hi;
            v1 = (sg && lo >= 32) ? lo - 64 : lo;
         end else begin
            v0 = (sg && c >= 2048) ? c - 4096 : c;
            v1 = 0;
         end
         s0 += v0;
         s1 += v1;
      end
      e.a0  = s0[23:0];
      e.a1  = s1[23:0];
      e.sp  = split;
      e.cnt = 8'(nb);
      sb.push_back(e);

      for (int i = 0; i < nb; i++) begin
         @(negedge clk);
         check_eq("out_valid_mid_frame", 32'(out_valid), 32'd0);
         in_valid = 1'b1;
         c_in     = beat_q[i];
         if (i == 0) begin
            half0 = h0; half1 = h1; sign_in = sg; len_in = ln;
         end else begin
            half0 = ~h0; half1 = ~h1; sign_in = ~sg; len_in = 8'($urandom_range(0, 255));
         end
         guard = 0;
         while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         if (!in_ready) check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      c_in     = 12'h000;
      beat_q.delete();
   endtask

   // Pops one expected frame and checks it across hold cycles, the handshake and afterwards.
   task automatic drain(input string tag, input int hold);
      exp_t e;
      e = sb.pop_front();
      check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      check_outputs(tag, e);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check_eq({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
         check_outputs({tag, "_hold"}, e);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq({tag, "_post_valid"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
      check_outputs({tag, "_post"}, e);
      $display("frame %s: acc0=%06h acc1=%06h split=%0d count=%0d", tag, e.a0, e.a1, e.sp, e.cnt);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; c_in = 12'h000; half0 = 1'b0; half1 = 1'b0;
      sign_in = 1'b0; len_in = 8'd0; out_ready = 1'b0;

      #2;
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_outputs("rst", '{a0: 24'd0, a1: 24'd0, sp: 1'b0, cnt: 8'd0});
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("idle_in_ready", 32'(in_ready), 32'd1);

      // Full unsigned, 63 x 63 twice
      beat_q = '{12'hF81, 12'hF81};
      send_frame(1'b1, 1'b0, 1'b0, 8'd2);
      drain("full_unsigned", 0);

      // Full signed, -32 x 31 three times
      beat_q = '{12'hC20, 12'hC20, 12'hC20};
      send_frame(1'b1, 1'b0, 1'b1, 8'd3);
      drain("full_signed", 0);

      // Split signed, lanes -6 and 9, held off for 5 cycles
      beat_q = '{12'hE89, 12'hE89};
      send_frame(1'b0, 1'b1, 1'b1, 8'd2);
      drain("split_backpressure", 5);

      // len=0 behaves as a single beat
      beat_q = '{12'h005};
      send_frame(1'b1, 1'b0, 1'b0, 8'd0);
      drain("len_zero", 1);

      // Both HALF bits set decodes to full mode
      beat_q = '{12'hABC, 12'h123};
      send_frame(1'b1, 1'b1, 1'b0, 8'd2);
      drain("both_half", 0);

      // Split unsigned
      beat_q = '{12'hFFF, 12'h041};
      send_frame(1'b0, 1'b1, 1'b0, 8'd2);
      drain("split_unsigned", 0);

      for (int f = 0; f < 6; f++) begin
         int   nb;
         logic [7:0] ln;
         ln = 8'($urandom_range(0, 5));
         nb = (ln == 0) ? 1 : int'(ln);
         for (int i = 0; i < nb; i++) beat_q.push_back(12'($urandom));
         send_frame(1'($urandom), 1'($urandom), 1'($urandom), ln);
         drain($sformatf("random%0d", f), int'($urandom_range(0, 2)));
      end

      // Reset in the middle of a len=4 frame
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         in_valid = 1'b1; c_in = 12'h7FF; half0 = 1'b1; half1 = 1'b0; sign_in = 1'b0; len_in = 8'd4;
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
      check_outputs("midrst", '{a0: 24'd0, a1: 24'd0, sp: 1'b0, cnt: 8'd0});
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_eq("midrst_no_valid", 32'(out_valid), 32'd0);
         check_eq("midrst_in_ready_idle", 32'(in_ready), 32'd1);
         check_outputs("midrst_after", '{a0: 24'd0, a1: 24'd0, sp: 1'b0, cnt: 8'd0});
      end

      beat_q = '{12'h003};
      send_frame(1'b1, 1'b0, 1'b0, 8'd1);
      drain("after_reset", 0);

      check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mult_c3x2_lane_accumulator.md
# mult_c3x2_lane_accumulator

Sequential consumer of the packed product word `C[11:0]` of the 6x6 / dual-3x3 precision-configurable multiplier. Each frame, it unpacks the word into one 12-bit lane or two 6-bit lanes. Each lane is sign- or zero-extended and accumulated over a programmable number of beats. The per-lane sums are then presented on a valid/ready output. It sits directly downstream of the multiplier and turns it into a MAC datapath.

## Interface
- `ACC_W`, 24, accumulator width per lane; must be ≥12.
- `CNT_W`, 8, width of the beat-count field.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `C` beat offered.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready` at a rising edge.
- `C`  in  12  packed product from the multiplier.
- `HALF_0`  in  1  full 6x6 mode select; sampled on the first beat of a frame only.
- `HALF_1`  in  1  dual 3x3 mode select; sampled on the first beat only.
- `sign`  in  1  products are signed (`A_sign & B_sign`); sampled on the first beat only.
- `len`  in  CNT_W  beats per frame; sampled on the first beat; 0 is treated as 1.
- `out_valid`  out  1  frame result available.
- `out_ready`  in  1  result consumed when `out_valid & out_ready` at a rising edge.
- `acc0`  out  ACC_W  lane-0 sum: full product, or upper lane `C[11:6]` in split mode.
- `acc1`  out  ACC_W  lane-1 sum: `C[5:0]` in split mode; 0 in full mode.
- `out_split`  out  1  result was produced in split mode.
- `out_count`  out  CNT_W  beats accumulated in this frame.

## Operation
- **Mode decode on the first beat**
  - split when `HALF_1 & ~HALF_0`; otherwise full mode.
  - `HALF_0=HALF_1=1` and `HALF_0=HALF_1=0` both decode to full mode.
- **Lane extension**
  - Full mode: the 12-bit lane is taken from `C[11:0]`.
  - Split mode: two 6-bit lanes, `C[11:6]` and `C[5:0]`.
  - Each lane is sign-extended to ACC_W if `sign` is set, zero-extended otherwise.
- **Arithmetic**
  - Two's-complement add, modulo 2^ACC_W.
  - Silent wrap; no saturation and no overflow flag.
- **FSM states:** IDLE, ACC, HOLD.
  - IDLE: `in_ready=1`. On accept: latch mode/sign/len, load the accumulators with the extended first beat, set count=1. Go to HOLD if effective len==1, else ACC.
  - ACC: `in_ready=1`. On accept: add the beat, count+1. Go to HOLD when the new count equals len.
  - HOLD: `in_ready=0`, `out_valid=1`. On `out_ready`, go to IDLE.
- **Input signal handling**
  - `C` is sampled only on accept.
  - `HALF_*`, `sign` and `len` are ignored on non-first beats.
- **Reset**
  - Asserting `rst_n` mid-frame discards the partial sum immediately.
  - The next frame starts clean in IDLE.

## Timing
- **Reset values:** `in_ready=0` while `rst_n` is low and 1 from the first cycle after release (IDLE); `out_valid=0`; `acc0=0`; `acc1=0`; `out_split=0`; `out_count=0`.
- **Latency:** `out_valid` rises the cycle after the final beat is accepted.
- **Output stability:** `acc0`, `acc1`, `out_split` and `out_count` are registered and remain stable while `out_valid & ~out_ready`.
- **Throughput:** one beat per cycle inside a frame. Each frame costs a minimum of 1 HOLD cycle, so a len=N frame occupies ≥N+1 cycles.
- **Output handshake:** `out_valid` never drops without `out_ready`. `in_ready` stays low in HOLD, so there is no simultaneous accept and emit.
- **Output registers after handshake:** the outputs keep their last values after the handshake until the next frame's first accept overwrites them.

## Structure
- **Package `mult_acc_pkg`:**
  - state enum {IDLE, ACC, HOLD}
  - lane-width constants: `FULL_W=12`, `HALF_W=6`
  - `MODE_FULL` / `MODE_SPLIT` encoding
- **Sub-module `mult_lane_extend`:**
  - Parameterised on input width and ACC_W; extends one lane per the sign bit.
  - Instantiated three times: one 12-bit and two 6-bit instances; the muxed result feeds the adders.

## Test plan
- **Full unsigned:** `HALF_0=1`, `sign=0`, len=2, `C=12'hF81` twice (63×63) → `acc0=24'h001F02`, `acc1=0`, `out_split=0`, `out_count=2`.
- **Full signed:** `sign=1`, len=3, `C=12'hC20` ×3 (−32×31) → `acc0=24'hFFF460` (−2976).
- **Split signed:** `HALF_1=1`, `HALF_0=0`, `sign=1`, len=2, `C=12'hE89` twice (−6 and 9) → `acc0=24'hFFFFF4`, `acc1=24'h000012`, `out_split=1`.
- **Backpressure:** result present, hold `out_ready=0` for 5 cycles → `out_valid=1`, outputs constant, `in_ready=0`. Release → IDLE next cycle with `in_ready=1`.
- **Wrap and len=0 (ACC_W=12):**
  - len=2, `C=12'hF81` ×2 → `acc0=12'hF02`.
  - len=0, single beat `12'h005` → `out_count=1`, `acc0=12'h005`.
- **Reset mid-frame:** len=4, 2 beats accepted, pulse `rst_n` low → `out_valid` never rises and all outputs are 0. A new len=1 frame with `C=12'h003` → `acc0=3`.
